// File: rtl/systolic_tile_engine.sv
`default_nettype none
// ============================================================================
// Module   : systolic_tile_engine
// Purpose  : Output-stationary N x N systolic array computing C (+)= A * B.
//            Operand beats (column k of A, row k of B) are skewed into the
//            array, each PE accumulates a*b into its own C[i][j], and the
//            finished tile is drained one row of C per handshake.
// Ports    : clk, rst            - rising-edge clock, sync active-high reset
//            start_i, k_len_i,
//            accumulate_i        - tile request (sampled in IDLE only)
//            busy_o              - high whenever not IDLE
//            in_valid_i/in_ready_o, a_vec_i, b_vec_i - operand beat stream
//            out_valid_o/out_ready_i, out_row_o, out_row_idx_o, out_last_o
//                                - result row stream
//            done_o              - one-cycle pulse after the last row is taken
// Revision : 1.0 - initial release
// ============================================================================
module systolic_tile_engine #(
  parameter int N      = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int K_W    = 8,
  parameter int SIGNED = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [K_W-1:0]         k_len_i,
  input  logic                   accumulate_i,
  output logic                   busy_o,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [N*DATA_W-1:0]    a_vec_i,
  input  logic [N*DATA_W-1:0]    b_vec_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [N*ACC_W-1:0]     out_row_o,
  output logic [$clog2(N)-1:0]   out_row_idx_o,
  output logic                   out_last_o,
  output logic                   done_o
);

  localparam int IDX_W  = $clog2(N);
  localparam int FL_W   = $clog2(2*N);
  localparam int PROD_W = 2*DATA_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_FLUSH = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [K_W-1:0]    k_len_q, beat_cnt_q;
  logic [FL_W-1:0]   flush_cnt_q;
  logic [IDX_W-1:0]  row_q;
  logic              done_q;
  logic              start_fire, beat_fire, row_fire;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    start_fire  = 1'b0;
    beat_fire   = 1'b0;
    row_fire    = 1'b0;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        // done_q marks the cycle right after the final row; a start there is dropped.
        if (start_i && !done_q) begin
          start_fire = 1'b1;
          state_d    = (k_len_i == '0) ? S_DRAIN : S_FEED;
        end
      end
      S_FEED: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          beat_fire = 1'b1;
          if (beat_cnt_q + K_W'(1) == k_len_q) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // 2N-1 cycles lets the last beat reach PE(N-1,N-1) and land in C.
        if (flush_cnt_q == FL_W'(2*N-2)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          row_fire = 1'b1;
          if (row_q == IDX_W'(N-1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_len_q     <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      row_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= row_fire && (row_q == IDX_W'(N-1));
      flush_cnt_q <= (state_q == S_FLUSH) ? flush_cnt_q + FL_W'(1) : '0;
      if (start_fire) begin
        k_len_q    <= k_len_i;
        beat_cnt_q <= '0;
        row_q      <= '0;
      end
      if (beat_fire) beat_cnt_q <= beat_cnt_q + K_W'(1);
      if (row_fire)  row_q <= (row_q == IDX_W'(N-1)) ? '0 : row_q + IDX_W'(1);
    end
  end

  assign out_row_idx_o = row_q;
  assign out_last_o    = out_valid_o && (row_q == IDX_W'(N-1));
  assign done_o        = done_q;

  // --------------------------------------------------------------------------
  // Operand injection and input skew (row/column i delayed by i cycles)
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] a_in [N];
  logic [DATA_W-1:0] b_in [N];
  logic [DATA_W-1:0] a_sk [N];
  logic [DATA_W-1:0] b_sk [N];
  logic              t_sk [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_in[i] = beat_fire ? a_vec_i[i*DATA_W +: DATA_W] : '0;
      b_in[i] = beat_fire ? b_vec_i[i*DATA_W +: DATA_W] : '0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_skew
      if (gi == 0) begin : g_direct
        assign a_sk[gi] = a_in[gi];
        assign b_sk[gi] = b_in[gi];
        assign t_sk[gi] = beat_fire;
      end else begin : g_delay
        logic [DATA_W-1:0] a_dly_q [gi];
        logic [DATA_W-1:0] b_dly_q [gi];
        logic              t_dly_q [gi];
        always_ff @(posedge clk) begin
          if (rst) begin
            for (int d = 0; d < gi; d++) begin
              a_dly_q[d] <= '0;
              b_dly_q[d] <= '0;
              t_dly_q[d] <= 1'b0;
            end
          end else begin
            a_dly_q[0] <= a_in[gi];
            b_dly_q[0] <= b_in[gi];
            t_dly_q[0] <= beat_fire;
            for (int d = 1; d < gi; d++) begin
              a_dly_q[d] <= a_dly_q[d-1];
              b_dly_q[d] <= b_dly_q[d-1];
              t_dly_q[d] <= t_dly_q[d-1];
            end
          end
        end
        assign a_sk[gi] = a_dly_q[gi-1];
        assign b_sk[gi] = b_dly_q[gi-1];
        assign t_sk[gi] = t_dly_q[gi-1];
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // PE grid: a and its tag move right, b moves down, C stays in place
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] a_pass_q   [N][N-1];
  logic              t_pass_q   [N][N-1];
  logic [DATA_W-1:0] b_pass_q   [N-1][N];
  logic [DATA_W-1:0] a_h        [N][N];
  logic [DATA_W-1:0] b_v        [N][N];
  logic              t_h        [N][N];
  logic [ACC_W-1:0]  prod       [N][N];
  logic [ACC_W-1:0]  c_q        [N][N];
  logic [PROD_W-1:0] p_full;

  always_comb begin
    p_full = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        a_h[i][j] = (j == 0) ? a_sk[i] : a_pass_q[i][(j == 0) ? 0 : j-1];
        t_h[i][j] = (j == 0) ? t_sk[i] : t_pass_q[i][(j == 0) ? 0 : j-1];
        b_v[i][j] = (i == 0) ? b_sk[j] : b_pass_q[(i == 0) ? 0 : i-1][j];
        // Full-width product, then sign/zero extension into the accumulator.
        if (SIGNED != 0) begin
          p_full     = PROD_W'($signed(a_h[i][j]) * $signed(b_v[i][j]));
          prod[i][j] = {{(ACC_W-PROD_W){p_full[PROD_W-1]}}, p_full};
        end else begin
          p_full     = PROD_W'(a_h[i][j]) * PROD_W'(b_v[i][j]);
          prod[i][j] = {{(ACC_W-PROD_W){1'b0}}, p_full};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N-1; j++) begin
          a_pass_q[i][j] <= '0;
          t_pass_q[i][j] <= 1'b0;
          b_pass_q[j][i] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N-1; j++) begin
          a_pass_q[i][j] <= a_h[i][j];
          t_pass_q[i][j] <= t_h[i][j];
          b_pass_q[j][i] <= b_v[j][i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (rst || (start_fire && !accumulate_i)) c_q[i][j] <= '0;
        else if (t_h[i][j])                       c_q[i][j] <= c_q[i][j] + prod[i][j];
      end
    end
  end

  always_comb begin
    out_row_o = '0;
    for (int j = 0; j < N; j++) out_row_o[j*ACC_W +: ACC_W] = c_q[row_q][j];
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_tile_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_tile_engine
// Purpose  : Self-checking bench for systolic_tile_engine. A signed and an
//            unsigned instance share all inputs; results are compared with a
//            plain matrix-product reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_tile_engine;

  localparam int N = 4;
  localparam int DW = 8;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [7:0]      k_len = '0;
  logic            accumulate = 1'b0;
  logic            in_valid = 1'b0;
  logic [N*DW-1:0] a_vec = '0;
  logic [N*DW-1:0] b_vec = '0;
  logic            out_ready = 1'b0;

  logic            busy_s, in_ready_s, out_valid_s, out_last_s, done_s;
  logic [N*AW-1:0] out_row_s;
  logic [1:0]      out_row_idx_s;
  logic            busy_u, in_ready_u, out_valid_u, out_last_u, done_u;
  logic [N*AW-1:0] out_row_u;
  logic [1:0]      out_row_idx_u;

  systolic_tile_engine #(.N(N), .DATA_W(DW), .ACC_W(AW), .K_W(8), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .start_i(start), .k_len_i(k_len), .accumulate_i(accumulate),
    .busy_o(busy_s), .in_valid_i(in_valid), .in_ready_o(in_ready_s),
    .a_vec_i(a_vec), .b_vec_i(b_vec), .out_valid_o(out_valid_s), .out_ready_i(out_ready),
    .out_row_o(out_row_s), .out_row_idx_o(out_row_idx_s), .out_last_o(out_last_s),
    .done_o(done_s));

  systolic_tile_engine #(.N(N), .DATA_W(DW), .ACC_W(AW), .K_W(8), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .start_i(start), .k_len_i(k_len), .accumulate_i(accumulate),
    .busy_o(busy_u), .in_valid_i(in_valid), .in_ready_o(in_ready_u),
    .a_vec_i(a_vec), .b_vec_i(b_vec), .out_valid_o(out_valid_u), .out_ready_i(out_ready),
    .out_row_o(out_row_u), .out_row_idx_o(out_row_idx_u), .out_last_o(out_last_u),
    .done_o(done_u));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Operands: A[i][k] (column k of A), B[k][j] (row k of B)
  logic [7:0]  A [N][16];
  logic [7:0]  B [16][N];
  logic [31:0] ref_s [N][N];
  logic [31:0] ref_u [N][N];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ref_s[i][j] = '0;
        ref_u[i][j] = '0;
      end
  endtask

  // C = (acc ? C : 0) + A(:,0..k-1) * B(0..k-1,:), modulo 2^32
  task automatic model_update(input int k, input bit acc);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int          ss;
        logic [31:0] su;
        ss = 0;
        su = '0;
        for (int kk = 0; kk < k; kk++) begin
          ss += $signed(A[i][kk]) * $signed(B[kk][j]);
          su += {24'd0, A[i][kk]} * {24'd0, B[kk][j]};
        end
        ref_s[i][j] = acc ? ref_s[i][j] + 32'(ss) : 32'(ss);
        ref_u[i][j] = acc ? ref_u[i][j] + su : su;
      end
  endtask

  task automatic load_identity_data();
    for (int kk = 0; kk < 16; kk++)
      for (int i = 0; i < N; i++) begin
        A[i][kk] = (i == kk) ? 8'd1 : 8'd0;
        B[kk][i] = 8'(4*kk + i);
      end
  endtask

  task automatic load_const_data(input logic [7:0] av, input logic [7:0] bv);
    for (int kk = 0; kk < 16; kk++)
      for (int i = 0; i < N; i++) begin
        A[i][kk] = av;
        B[kk][i] = bv;
      end
  endtask

  task automatic load_random_data();
    for (int kk = 0; kk < 16; kk++)
      for (int i = 0; i < N; i++) begin
        A[i][kk] = 8'($urandom);
        B[kk][i] = 8'($urandom);
      end
  endtask

  task automatic drive_beat(input int kk);
    for (int i = 0; i < N; i++) begin
      a_vec[i*DW +: DW] = A[i][kk];
      b_vec[i*DW +: DW] = B[kk][i];
    end
  endtask

  // Reset for one edge; every output must read zero in the following cycle.
  task automatic reset_and_check();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    check("rst_busy",     busy_s, 0);
    check("rst_in_ready", in_ready_s, 0);
    check("rst_valid",    out_valid_s, 0);
    check("rst_last",     out_last_s, 0);
    check("rst_done",     done_s, 0);
    check("rst_idx",      out_row_idx_s, 0);
    check("rst_row",      out_row_s, 0);
    check("rst_row_u",    out_row_u, 0);
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    while (!out_valid_s && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_seen", out_valid_s, 1);
  endtask

  task automatic run_tile(input int k, input bit acc, input bit rand_valid, input int stall_row);
    int             beat, t_last, n;
    logic [127:0]   held, exp_s, exp_u;
    @(negedge clk);
    start = 1'b1; k_len = 8'(k); accumulate = acc; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    model_update(k, acc);
    check("busy_after_start", busy_s, 1);
    beat = 0; t_last = 0; n = 0;
    while (beat < k && n < 200) begin
      in_valid = rand_valid ? ($urandom_range(0, 2) != 0) : 1'b1;
      drive_beat(beat);
      if (in_valid && in_ready_s) begin
        t_last = cyc;
        beat++;
      end
      n++;
      @(negedge clk);
    end
    in_valid = 1'b0; a_vec = '0; b_vec = '0;
    if (k > 0) check("beats_accepted", beat, k);
    wait_out_valid();
    check("out_valid_u", out_valid_u, 1);
    if (k > 0) check("latency", cyc - t_last, 2*N);
    for (int r = 0; r < N; r++) begin
      wait_out_valid();
      if (r == stall_row) begin
        out_ready = 1'b0;
        held = out_row_s;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          check("stall_row", out_row_s, held);
          check("stall_idx", out_row_idx_s, r);
          check("stall_valid", out_valid_s, 1);
        end
      end
      out_ready = 1'b1;
      exp_s = '0; exp_u = '0;
      for (int j = 0; j < N; j++) begin
        exp_s[j*AW +: AW] = ref_s[r][j];
        exp_u[j*AW +: AW] = ref_u[r][j];
      end
      check("row_idx",  out_row_idx_s, r);
      check("row_last", out_last_s, (r == N-1));
      check("row_s",    out_row_s, exp_s);
      check("row_u",    out_row_u, exp_u);
      check("no_done",  done_s, 0);
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("done_pulse", done_s, 1);
    check("done_u",     done_u, 1);
    check("idle_busy",  busy_s, 0);
    // A start in the done cycle must be dropped (it would otherwise clear C).
    start = 1'b1; k_len = 8'd2; accumulate = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("start_ignored", busy_s, 0);
    check("done_once",     done_s, 0);
  endtask

  initial begin
    model_clear();
    load_identity_data();
    reset_and_check();

    // Identity A -> rows equal B
    run_tile(4, 1'b0, 1'b0, -1);

    // 0xFF * 0x02 over k=3: -6 signed, 1530 unsigned
    load_const_data(8'hFF, 8'h02);
    run_tile(3, 1'b0, 1'b0, -1);

    // Gappy in_valid, then back-pressure on row 1
    load_identity_data();
    run_tile(4, 1'b0, 1'b1, -1);
    run_tile(4, 1'b0, 1'b0, 1);

    // Accumulation chain: B, 2B, then 2B again with k_len=0
    run_tile(4, 1'b0, 1'b0, -1);
    run_tile(4, 1'b1, 1'b0, -1);
    run_tile(0, 1'b1, 1'b0, -1);

    // Reset after two FEED beats, then a clean tile
    @(negedge clk);
    start = 1'b1; k_len = 8'd4; accumulate = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1;
      drive_beat(b);
      @(negedge clk);
    end
    in_valid = 1'b0;
    reset_and_check();
    run_tile(4, 1'b0, 1'b0, -1);

    // Random data, lengths, accumulate flags, valid gaps and stalls
    for (int it = 0; it < 6; it++) begin
      load_random_data();
      run_tile($urandom_range(1, 9), 1'($urandom_range(0, 1)), 1'b1,
               int'($urandom_range(0, 4)) - 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
